// File: rtl/shift_op_sequencer.sv
// -----------------------------------------------------------------------------
// shift_op_sequencer
//
// Multi-cycle controller for the ALU invert-and-right-shift operation. One
// operand pair is accepted per valid/ready handshake; ~A is shifted right by
// one position per cycle on a single shift stage, then a 4-bit status word is
// evaluated and the result is held until the consumer takes it.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_valid    operand pair valid
//   o_ready    ready to accept operands (only in IDLE)
//   i_arg_A    operand A (bit-inverted before shifting)
//   i_arg_B    signed shift amount
//   o_valid    result valid (only in DONE)
//   i_ready    consumer accepts result
//   o_newA     result
//   o_status   [3] range error, [2] all ones, [1] even parity & nonzero,
//              [0] negative B
//   o_busy     high while shifting or evaluating
//   o_err_cnt  saturating count of delivered results with status[3]|status[0]
// -----------------------------------------------------------------------------
module shift_op_sequencer #(
    parameter int M     = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [M-1:0]     i_arg_A,
    input  logic [M-1:0]     i_arg_B,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [M-1:0]     o_newA,
    output logic [3:0]       o_status,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_err_cnt
);

    // Shift counter must be able to hold the clamped value M itself.
    localparam int N_W = $clog2(M + 1);
    localparam logic [M-1:0] M_VAL = M[M-1:0];
    localparam logic [M-1:0] LIM   = M_VAL - {{(M-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EVAL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    logic [M-1:0]   sh;
    logic [N_W-1:0] cnt;
    logic           neg;

    logic [N_W-1:0] n_load;
    logic [M-1:0]   eval_a;
    logic [3:0]     eval_st;

    // Even parity helper: 1 when the vector holds an even number of ones.
    function automatic logic even_parity(input logic [M-1:0] v);
        return ~(^v);
    endfunction

    // Clamp the signed shift amount to 0..M; negative amounts do no shifting.
    always_comb begin
        n_load = '0;
        if (i_arg_B[M-1]) begin
            n_load = '0;
        end else if (i_arg_B >= M_VAL) begin
            n_load = N_W'(M);
        end else begin
            n_load = N_W'(i_arg_B);
        end
    end

    // Result and status evaluation from the fully shifted value.
    always_comb begin
        eval_a  = '0;
        eval_st = 4'b0000;
        if (neg) begin
            eval_st[0] = 1'b1;
        end else if (sh > LIM) begin
            eval_st[3] = 1'b1;
        end else begin
            eval_a = sh;
        end
        // Flags [2:1] always describe the value actually delivered.
        eval_st[2] = &eval_a;
        eval_st[1] = even_parity(eval_a) & (|eval_a);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            sh        <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            o_ready   <= 1'b1;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_newA    <= '0;
            o_status  <= 4'b0000;
            o_err_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    if (i_valid) begin
                        sh      <= ~i_arg_A;
                        neg     <= i_arg_B[M-1];
                        cnt     <= n_load;
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                        if (n_load != '0) begin
                            state <= SHIFT;
                        end else begin
                            state <= EVAL;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sh  <= {1'b0, sh[M-1:1]};
                    cnt <= cnt - N_W'(1);
                    if (cnt == N_W'(1)) begin
                        state <= EVAL;
                    end else begin
                        state <= SHIFT;
                    end
                end
                EVAL: begin
                    o_newA   <= eval_a;
                    o_status <= eval_st;
                    o_valid  <= 1'b1;
                    o_busy   <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                        if ((o_status[3] | o_status[0]) &&
                            (o_err_cnt != {CNT_W{1'b1}})) begin
                            o_err_cnt <= o_err_cnt + CNT_W'(1);
                        end else begin
                            o_err_cnt <= o_err_cnt;
                        end
                    end else begin
                        state <= DONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_op_sequencer
//
// Self-checking bench for shift_op_sequencer: directed cases, randomized
// operands with random consumer back-pressure, reset during an operation and
// error-counter saturation. Expected values come from an arithmetic model.
// -----------------------------------------------------------------------------
module tb_shift_op_sequencer;

    localparam int M     = 8;
    localparam int CNT_W = 8;

    logic             i_clk;
    logic             i_rst;
    logic             i_valid;
    logic             o_ready;
    logic [M-1:0]     i_arg_A;
    logic [M-1:0]     i_arg_B;
    logic             o_valid;
    logic             i_ready;
    logic [M-1:0]     o_newA;
    logic [3:0]       o_status;
    logic             o_busy;
    logic [CNT_W-1:0] o_err_cnt;

    int tests_run;
    int tests_failed;
    int exp_err;

    shift_op_sequencer #(.M(M), .CNT_W(CNT_W)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_arg_A   (i_arg_A),
        .i_arg_B   (i_arg_B),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_newA    (o_newA),
        .o_status  (o_status),
        .o_busy    (o_busy),
        .o_err_cnt (o_err_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: result of inverting A, shifting by the clamped signed B,
    // and classifying the outcome.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output int n, output logic [7:0] na,
                                  output logic [3:0] st);
        int sb;
        int v;
        int ones;
        sb = int'($signed(b));
        st = 4'b0000;
        na = 8'h00;
        if (sb < 0) begin
            n     = 0;
            st[0] = 1'b1;
        end else begin
            n = (sb > M) ? M : sb;
            v = (255 - int'(a)) / (2 ** n);
            if (v > M - 1) st[3] = 1'b1;
            else           na = v[7:0];
        end
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(na[i]);
        st[2] = (na == 8'hFF);
        st[1] = ((ones % 2) == 0) && (na != 8'h00);
    endfunction

    // Run one operation; hold i_ready low for 'hold' cycles in DONE.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold);
        int n;
        int cyc;
        logic [7:0] na;
        logic [3:0] st;
        model(a, b, n, na, st);
        @(negedge i_clk);
        check("ready_idle", 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_arg_A = a;
        i_arg_B = b;
        @(posedge i_clk);
        cyc = 1;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_arg_A = 8'($urandom);
        i_arg_B = 8'($urandom);
        if (!o_valid) check("busy", 32'(o_busy), 32'd1);
        while (!o_valid && cyc < 40) begin
            @(posedge i_clk);
            cyc++;
            @(negedge i_clk);
        end
        check("valid", 32'(o_valid), 32'd1);
        check("latency", 32'(cyc), 32'(n + 2));
        check("newA", 32'(o_newA), 32'(na));
        check("status", 32'(o_status), 32'(st));
        check("ready_done", 32'(o_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            i_valid = 1'($urandom);
            i_arg_A = 8'($urandom);
            i_arg_B = 8'($urandom);
            @(posedge i_clk);
            @(negedge i_clk);
            check("hold_valid", 32'(o_valid), 32'd1);
            check("hold_newA", 32'(o_newA), 32'(na));
            check("hold_status", 32'(o_status), 32'(st));
            check("hold_ready", 32'(o_ready), 32'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ready = 1'b0;
        if (st[3] | st[0]) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        check("valid_drop", 32'(o_valid), 32'd0);
        check("ready_back", 32'(o_ready), 32'd1);
        check("kept_newA", 32'(o_newA), 32'(na));
        check("err_cnt", 32'(o_err_cnt), 32'(exp_err));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_err      = 0;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_arg_A = 8'h00;
        i_arg_B = 8'h00;
        repeat (2) @(negedge i_clk);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_newA", 32'(o_newA), 32'd0);
        check("rst_status", 32'(o_status), 32'd0);
        check("rst_err", 32'(o_err_cnt), 32'd0);
        i_rst = 1'b0;

        // Directed cases
        do_op(8'h9F, 8'd5, 0);
        do_op(8'h0F, 8'd2, 0);
        do_op(8'h3C, 8'hFF, 0);
        do_op(8'h00, 8'd20, 0);
        do_op(8'h9F, 8'd5, 4);
        do_op(8'hFF, 8'd0, 1);
        do_op(8'h55, 8'd7, 2);

        // Randomized operands and back-pressure
        for (int i = 0; i < 60; i++) begin
            do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a shift
        @(negedge i_clk);
        i_valid = 1'b1;
        i_arg_A = 8'h9F;
        i_arg_B = 8'd5;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        check("mid_busy", 32'(o_busy), 32'd1);
        i_rst = 1'b1;
        #1;
        check("arst_ready", 32'(o_ready), 32'd1);
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_busy", 32'(o_busy), 32'd0);
        check("arst_newA", 32'(o_newA), 32'd0);
        check("arst_status", 32'(o_status), 32'd0);
        check("arst_err", 32'(o_err_cnt), 32'd0);
        exp_err = 0;
        @(negedge i_clk);
        i_rst = 1'b0;
        do_op(8'h9F, 8'd5, 0);

        // Error-counter saturation
        for (int i = 0; i < 300; i++) begin
            do_op(8'($urandom), 8'($urandom_range(128, 255)), 0);
        end
        check("err_sat", 32'(o_err_cnt), 32'd255);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
